// File: rtl/inert_spi_frame_ctrl.sv
// SPI-slave frame sequencer: decodes {R/Wn, addr[6:0], data[7:0]} frames into accesses of an external 128x8 bank.
// Optional INERT_BURST_EN: keep streaming bytes at auto-incrementing addresses instead of stopping after 16 bits.
//
// state | meaning
// IDLE  | waiting for the first SCLK edge of a frame (SS_n low)
// CMD   | shifting in R/Wn and address bits
// DATA  | shifting data in / response out, strobes issued here
// DONE  | frame complete, ignore MOSI until SS_n rises
module inert_spi_frame_ctrl #(
    parameter logic [6:0] CLR_ADDR   = 7'h22,
    parameter logic [7:0] WRITE_RESP = 8'hA5
) (
    input  logic       SCLK,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [6:0] reg_addr,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    output logic       clr_int,
    output logic       busy,
    output logic [7:0] abort_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [6:0] rx_shft;
    logic [7:0] tx_shft;
    logic       rw, rw_nxt;
    logic [6:0] addr_nxt;
    logic [6:0] cmd_addr;
    logic       rd_en_nxt, clr_nxt;
    logic       frm_last;
    logic       frm_start;
    logic       partial;
    logic       frm_rst_n;

    // Frame logic lives only while the slave is selected.
    assign frm_rst_n = rst_n & ~SS_n;
    assign cmd_addr  = {rx_shft[5:0], MOSI};
    assign frm_start = (state == S_IDLE) & ~SS_n;

    always_ff @(posedge SCLK or negedge frm_rst_n) begin
        if (!frm_rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            rx_shft   <= 7'd0;
            rw        <= 1'b0;
            reg_addr  <= 7'd0;
            reg_rd_en <= 1'b0;
            clr_int   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            rx_shft   <= {rx_shft[5:0], MOSI};
            rw        <= rw_nxt;
            reg_addr  <= addr_nxt;
            reg_rd_en <= rd_en_nxt;
            clr_int   <= clr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        rw_nxt      = rw;
        addr_nxt    = reg_addr;
        rd_en_nxt   = 1'b0;
        clr_nxt     = 1'b0;
        frm_last    = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt   = S_CMD;
                bit_cnt_nxt = 4'd1;
            end
            S_CMD: begin
                bit_cnt_nxt = bit_cnt + 4'd1;
                if (bit_cnt == 4'd7) begin
                    state_nxt = S_DATA;
                    rw_nxt    = rx_shft[6];
                    addr_nxt  = cmd_addr;
                    rd_en_nxt = rx_shft[6];
                    clr_nxt   = rx_shft[6] && (cmd_addr == CLR_ADDR);
                end
            end
            S_DATA: begin
                bit_cnt_nxt = bit_cnt + 4'd1;
                if (bit_cnt == 4'd15) begin
                    frm_last = 1'b1;
`ifdef INERT_BURST_EN
                    // Next byte of the burst: wrap the bit counter back to the data phase.
                    bit_cnt_nxt = 4'd8;
                    addr_nxt    = reg_addr + 7'd1;
                    rd_en_nxt   = rw;
                    clr_nxt     = rw && (addr_nxt == CLR_ADDR);
`else
                    state_nxt   = S_DONE;
                    bit_cnt_nxt = 4'd0;
`endif
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Response byte loads on the falling edge after the command byte, then shifts out MSB first.
    always_ff @(negedge SCLK or negedge frm_rst_n) begin
        if (!frm_rst_n) begin
            tx_shft <= 8'd0;
        end else if (state == S_DATA) begin
            if (bit_cnt == 4'd8)
                tx_shft <= rw ? reg_rd_data : WRITE_RESP;
            else
                tx_shft <= {tx_shft[6:0], 1'b0};
        end
    end

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            partial   <= 1'b0;
            abort_cnt <= 8'd0;
        end else if (frm_start) begin
            partial <= 1'b1;
            if (partial && (abort_cnt != 8'hFF))
                abort_cnt <= abort_cnt + 8'd1;
        end else if (frm_last) begin
            partial <= 1'b0;
        end
    end

    assign busy        = (state != S_IDLE);
    assign reg_wr_en   = (state == S_DATA) && (bit_cnt == 4'd15) && !rw;
    assign reg_wr_data = frm_rst_n ? {rx_shft[6:0], MOSI} : 8'h00;
    assign MISO        = frm_rst_n ? ((state == S_DATA) ? tx_shft[7] : 1'b0) : 1'bz;

endmodule

// File: tb/tb_inert_spi_frame_ctrl.sv
// Directed bench for inert_spi_frame_ctrl: table of 16-bit frames plus hand-written abort, reset and burst sequences.
// Expectations for the 32-bit read follow INERT_BURST_EN when the bench is built with it.
module tb_inert_spi_frame_ctrl;

    logic       SCLK = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    wire        MISO;
    logic [6:0] reg_addr;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       clr_int;
    logic       busy;
    logic [7:0] abort_cnt;

    logic [7:0] bank [0:127];

    inert_spi_frame_ctrl dut (
        .SCLK(SCLK), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .reg_addr(reg_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
        .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .clr_int(clr_int),
        .busy(busy), .abort_cnt(abort_cnt)
    );

    always #5 SCLK = ~SCLK;

    assign reg_rd_data = bank[reg_addr];
    always @(posedge SCLK) if (reg_wr_en) bank[reg_addr] <= reg_wr_data;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] cap_miso;
    int          cap_rd, cap_rd_pos, cap_clr, cap_wr;
    logic [6:0]  cap_wa;
    logic [7:0]  cap_wd;
    logic [7:0]  cap_abort;
    logic        cap_busy_pre, cap_busy_post;

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        logic [7:0]  miso;
        int          rd;
        int          rd_pos;
        int          clr;
        int          wr;
        logic [6:0]  wa;
        logic [7:0]  wd;
        logic [7:0]  abort;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    // Clocks a frame MSB first; MISO and wr strobe sampled before each rising edge, rd/clr after.
    task automatic run_frame(input logic [31:0] frm, input int nbits);
        cap_miso = 32'h0; cap_rd = 0; cap_rd_pos = -1; cap_clr = 0; cap_wr = 0;
        cap_wa = 7'h0; cap_wd = 8'h0; cap_abort = 8'h0; cap_busy_pre = 1'b0; cap_busy_post = 1'b0;
        @(negedge SCLK); #1;
        SS_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) begin @(negedge SCLK); #1; end
            MOSI = frm[31-i];
            #1;
            cap_miso[31-i] = MISO;
            if (i == 0) cap_busy_pre = busy;
            if (reg_wr_en) begin cap_wr++; cap_wa = reg_addr; cap_wd = reg_wr_data; end
            @(posedge SCLK); #1;
            if (i == 0) begin cap_abort = abort_cnt; cap_busy_post = busy; end
            if (i < nbits - 1) begin
                if (reg_rd_en) begin cap_rd++; if (cap_rd_pos < 0) cap_rd_pos = i; end
                if (clr_int) cap_clr++;
            end
        end
    endtask

    task automatic end_frame();
        @(negedge SCLK); #1;
        SS_n = 1'b1;
        MOSI = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 128; a++) bank[a] = 8'h00;
        bank[7'h2C] = 8'h5A;
        bank[7'h22] = 8'h3C;
        bank[7'h00] = 8'h96;
        bank[7'h01] = 8'hE1;

        //         frame    nb  miso   rd pos clr wr  wa     wd     abort
        vt[0] = '{16'h0D02, 16, 8'hA5, 0, -1, 0, 1, 7'h0D, 8'h02, 8'h00};
        vt[1] = '{16'hAC00, 16, 8'h5A, 1,  7, 0, 0, 7'h00, 8'h00, 8'h00};
        vt[2] = '{16'hA200, 16, 8'h3C, 1,  7, 1, 0, 7'h00, 8'h00, 8'h00};
        vt[3] = '{16'h3377, 16, 8'hA5, 0, -1, 0, 1, 7'h33, 8'h77, 8'h00};
        vt[4] = '{16'hB300, 16, 8'h77, 1,  7, 0, 0, 7'h00, 8'h00, 8'h00};
        vt[5] = '{16'h7FC3, 16, 8'hA5, 0, -1, 0, 1, 7'h7F, 8'hC3, 8'h00};
        vt[6] = '{16'hFF00, 16, 8'hC3, 1,  7, 0, 0, 7'h00, 8'h00, 8'h00};
        vt[7] = '{16'h1150, 11, 8'h00, 0, -1, 0, 0, 7'h00, 8'h00, 8'h00};
        vt[8] = '{16'h9100, 16, 8'h00, 1,  7, 0, 0, 7'h00, 8'h00, 8'h01};
        vt[9] = '{16'h8D00, 16, 8'h02, 1,  7, 0, 0, 7'h00, 8'h00, 8'h01};

        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        #12;
        chk("rst_addr",   {25'd0, reg_addr},    32'h0);
        chk("rst_rd_en",  {31'd0, reg_rd_en},   32'h0);
        chk("rst_wr_en",  {31'd0, reg_wr_en},   32'h0);
        chk("rst_wdata",  {24'd0, reg_wr_data}, 32'h0);
        chk("rst_clr",    {31'd0, clr_int},     32'h0);
        chk("rst_busy",   {31'd0, busy},        32'h0);
        chk("rst_abort",  {24'd0, abort_cnt},   32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge SCLK);

        for (int k = 0; k < 10; k++) begin
            run_frame({vt[k].frame, 16'h0000}, vt[k].nbits);
            chk($sformatf("v%0d_busy_pre", k),  {31'd0, cap_busy_pre},  32'h0);
            chk($sformatf("v%0d_busy_post", k), {31'd0, cap_busy_post}, 32'h1);
            chk($sformatf("v%0d_abort", k), {24'd0, cap_abort}, {24'd0, vt[k].abort});
            chk($sformatf("v%0d_miso_cmd", k), {24'd0, cap_miso[31:24]}, 32'h0);
            if (vt[k].nbits >= 16)
                chk($sformatf("v%0d_miso_data", k), {24'd0, cap_miso[23:16]}, {24'd0, vt[k].miso});
            chk($sformatf("v%0d_rd", k),     cap_rd,     vt[k].rd);
            chk($sformatf("v%0d_rd_pos", k), cap_rd_pos, vt[k].rd_pos);
            chk($sformatf("v%0d_clr", k),    cap_clr,    vt[k].clr);
            chk($sformatf("v%0d_wr", k),     cap_wr,     vt[k].wr);
            if (vt[k].wr > 0) begin
                chk($sformatf("v%0d_wa", k), {25'd0, cap_wa}, {25'd0, vt[k].wa});
                chk($sformatf("v%0d_wd", k), {24'd0, cap_wd}, {24'd0, vt[k].wd});
            end
            end_frame();
            #1;
            chk($sformatf("v%0d_busy_end", k), {31'd0, busy}, 32'h0);
            repeat (2) @(negedge SCLK);
        end

        // SS_n rising while the read strobes are high drops them at once.
        run_frame({16'hA200, 16'h0000}, 8);
        chk("abt_rd_hi",  {31'd0, reg_rd_en}, 32'h1);
        chk("abt_clr_hi", {31'd0, clr_int},   32'h1);
        end_frame();
        #1;
        chk("abt_rd_lo",   {31'd0, reg_rd_en}, 32'h0);
        chk("abt_clr_lo",  {31'd0, clr_int},   32'h0);
        chk("abt_busy_lo", {31'd0, busy},      32'h0);
        chk("abt_addr_lo", {25'd0, reg_addr},  32'h0);

        // Saturation: 300 short frames on top of one pending abort.
        for (int k = 0; k < 300; k++) begin
            run_frame(32'h0, 3);
            if (k == 0)   chk("sat_k0",   {24'd0, cap_abort}, 32'd2);
            if (k == 252) chk("sat_k252", {24'd0, cap_abort}, 32'd254);
            if (k == 253) chk("sat_k253", {24'd0, cap_abort}, 32'd255);
            if (k == 299) chk("sat_k299", {24'd0, cap_abort}, 32'd255);
            end_frame();
        end

        // Reset while a write strobe is high: everything returns to reset values immediately.
        run_frame({16'h4455, 16'h0000}, 15);
        chk("rstm_wr_hi", {31'd0, reg_wr_en}, 32'h1);
        chk("rstm_addr",  {25'd0, reg_addr},  32'h44);
        MOSI = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rstm_addr0",  {25'd0, reg_addr},    32'h0);
        chk("rstm_rd0",    {31'd0, reg_rd_en},   32'h0);
        chk("rstm_wr0",    {31'd0, reg_wr_en},   32'h0);
        chk("rstm_wdata0", {24'd0, reg_wr_data}, 32'h0);
        chk("rstm_clr0",   {31'd0, clr_int},     32'h0);
        chk("rstm_busy0",  {31'd0, busy},        32'h0);
        chk("rstm_abort0", {24'd0, abort_cnt},   32'h0);
        SS_n = 1'b1; MOSI = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) @(negedge SCLK);
        chk("rstm_nowrite", {24'd0, bank[7'h44]}, 32'h0);

        // 32-bit read starting at 0x7F.
        run_frame(32'hFF00_0000, 32);
        chk("bst_byte1", {24'd0, cap_miso[23:16]}, 32'hC3);
`ifdef INERT_BURST_EN
        chk("bst_byte2", {24'd0, cap_miso[15:8]}, 32'h96);
        chk("bst_byte3", {24'd0, cap_miso[7:0]},  32'hE1);
        chk("bst_rd",    cap_rd, 3);
`else
        chk("bst_byte2", {24'd0, cap_miso[15:8]}, 32'h00);
        chk("bst_byte3", {24'd0, cap_miso[7:0]},  32'h00);
        chk("bst_rd",    cap_rd, 1);
`endif
        chk("bst_abort", {24'd0, cap_abort}, 32'h0);
        end_frame();
        repeat (2) @(negedge SCLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
